// File: rtl/udp_tx_pkg.sv
// Shared FSM encoding and sizing helper for the UDP transmit scheduler.
package udp_tx_pkg;

   localparam int TX_ADR_W = 10;

   typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, SEND, GAP} tx_state_t;

   function automatic int adr_width(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

endpackage

// File: rtl/tx_frame_ram.sv
// Two-bank payload buffer: one write port, one registered read port (1 cycle latency).
// No backpressure; the read register clears on reset so tx_ram_data starts at zero.
module tx_frame_ram #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_adr,
   input  logic [7:0]    wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_adr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [0:(2**(AW+1))-1];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[{wr_bank, wr_adr}] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rd_data <= '0;
      else
         rd_data <= mem[{rd_bank, rd_adr}];
   end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Ping-pong ADC frame buffer feeding the UDP transmitter; one-cycle tx_start per full bank, 1-cycle payload read.
// No backpressure on the ADC: with both banks full, whole frames are discarded and counted.
module udp_tx_scheduler
   import udp_tx_pkg::*;
#(
   parameter int PAYLOAD_LEN  = 1024,
   parameter int IFG_CYCLES   = 256,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic                clk20,
   input  logic                rst,
   input  logic                enable,
   input  logic [7:0]          adc_data,
   input  logic                adc_valid,
   output logic                tx_start,
   input  logic                tx_busy,
   input  logic [TX_ADR_W-1:0] tx_ram_adr,
   output logic [7:0]          tx_ram_data,
   output logic                overflow,
   output logic                timeout_err,
   output logic [15:0]         frame_cnt,
   output logic [15:0]         drop_cnt
);

   localparam int            AW       = adr_width(PAYLOAD_LEN);
   localparam logic [AW-1:0] LAST_PTR = AW'(PAYLOAD_LEN - 1);
   localparam logic [15:0]   TMO_LAST = 16'(BUSY_TIMEOUT - 1);
   localparam logic [15:0]   IFG_LAST = 16'(IFG_CYCLES - 1);

   tx_state_t     state, state_nxt;
   logic [1:0]    full, full_nxt;
   logic          wr_bank, wr_active, discard, rd_bank, next_rd;
   logic [AW-1:0] wr_ptr;
   logic [15:0]   cyc_cnt;
   logic          full_clr, tmo_hit, accept, wr_last, full_set, tgt_bank, tgt_full;

   always_comb begin
      accept   = adc_valid && wr_active;
      wr_last  = (wr_ptr == LAST_PTR);
      full_set = accept && wr_last && !discard;
      tgt_bank = discard ? wr_bank : ~wr_bank;
      // A bank released by the reader this very cycle can take the next frame.
      tgt_full = full[tgt_bank] && !(full_clr && (rd_bank == tgt_bank));
      full_nxt = full;
      if (full_clr)
         full_nxt[rd_bank] = 1'b0;
      if (full_set)
         full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk20) begin
      if (rst) begin
         full      <= '0;
         wr_bank   <= 1'b0;
         wr_ptr    <= '0;
         wr_active <= 1'b0;
         discard   <= 1'b0;
         overflow  <= 1'b0;
         drop_cnt  <= '0;
      end else begin
         full     <= full_nxt;
         overflow <= 1'b0;
         // wr_active low implies wr_ptr is at a frame boundary.
         if (!wr_active)
            wr_active <= enable;
         if (accept) begin
            if (wr_last) begin
               wr_ptr    <= '0;
               wr_active <= enable;
               discard   <= tgt_full;
               if (!discard)
                  wr_bank <= ~wr_bank;
               if (tgt_full) begin
                  drop_cnt <= drop_cnt + 16'd1;
                  overflow <= !discard;
               end
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      full_clr  = 1'b0;
      tmo_hit   = 1'b0;
      case (state)
         IDLE:
            if (full[next_rd] && !tx_busy)
               state_nxt = START;
         START: begin
            tx_start  = 1'b1;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY:
            if (tx_busy) begin
               state_nxt = SEND;
            end else if (cyc_cnt == TMO_LAST) begin
               tmo_hit   = 1'b1;
               state_nxt = GAP;
            end
         SEND:
            if (!tx_busy) begin
               full_clr  = 1'b1;
               state_nxt = GAP;
            end
         GAP:
            if (cyc_cnt == IFG_LAST)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk20) begin
      if (rst) begin
         state       <= IDLE;
         cyc_cnt     <= '0;
         rd_bank     <= 1'b0;
         next_rd     <= 1'b0;
         frame_cnt   <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cyc_cnt     <= (state_nxt != state) ? '0 : cyc_cnt + 16'd1;
         timeout_err <= tmo_hit;
         if (state == START)
            rd_bank <= next_rd;
         if (full_clr) begin
            next_rd   <= ~next_rd;
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   tx_frame_ram #(.AW(AW)) u_ram (
      .clk     (clk20),
      .rst     (rst),
      .wr_en   (accept && !discard),
      .wr_bank (wr_bank),
      .wr_adr  (wr_ptr),
      .wr_data (adc_data),
      .rd_bank (rd_bank),
      .rd_adr  (tx_ram_adr[AW-1:0]),
      .rd_data (tx_ram_data)
   );

endmodule
